stepper_move_sequencer: RTL

//  Executes one two-axis move. Takes step counts and directions from the step-calculation

---
 rtl/stepper_move_sequencer_if.sv | 24 ++
 rtl/stepper_move_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_sequencer_if.sv
// Command channel from the step-calculation stage into the move sequencer.
//   master : drives cmd_valid, cmd_steps1/2, cmd_dir1/2; receives cmd_ready
//   slave  : receives the command fields; drives cmd_ready
// A command is consumed on a clock edge where cmd_valid && cmd_ready.
interface stepper_move_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps1;
  logic [CNT_W-1:0] cmd_steps2;
  logic             cmd_dir1;
  logic             cmd_dir2;

  modport master (
    output cmd_valid, cmd_steps1, cmd_steps2, cmd_dir1, cmd_dir2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps1, cmd_steps2, cmd_dir1, cmd_dir2,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_move_sequencer.sv
// Two-axis move sequencer: accepts one move (step counts + directions) and
// drives both stepper drivers' STEP/DIR pins.  Both axes pulse in shared
// time slots, so a move lasts max(steps1, steps2) slots.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   io_cmd         command channel (slave side; cmd_ready high only in IDLE)
//   i_abort        stop the current move at once (ignored in IDLE)
//   o_step1/2      STEP pins, registered, high only during HIGH
//   o_dir1/2       DIR pins, updated only on command accept
//   o_busy         move in progress (any state except IDLE)
//   o_done         1-cycle pulse, move completed normally
//   o_aborted      1-cycle pulse, move ended by abort
//   o_remaining1/2 pulses not yet issued per axis
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready = 1
// S_SETUP | DIR pins settling before the first STEP edge (DIR_SETUP cycles)
// S_HIGH  | STEP high on axes with pulses left (PULSE_WIDTH cycles)
// S_LOW   | STEP low, rest of the slot (STEP_PERIOD-PULSE_WIDTH cycles)
// S_DONE  | one cycle, done pulse
module stepper_move_sequencer #(
  parameter int CNT_W       = 8,
  parameter int STEP_PERIOD = 50000,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  stepper_move_sequencer_if.slave  io_cmd,
  input  logic                     i_abort,
  output logic                     o_step1,
  output logic                     o_step2,
  output logic                     o_dir1,
  output logic                     o_dir2,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic [CNT_W-1:0]         o_remaining1,
  output logic [CNT_W-1:0]         o_remaining2
);

  localparam int PH_MAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // Phase counter load values: a state lasting N cycles loads N-1 and
  // leaves when the counter reads zero.
  localparam logic [PH_W-1:0] LD_SETUP = PH_W'(DIR_SETUP - 1);
  localparam logic [PH_W-1:0] LD_HIGH  = PH_W'(PULSE_WIDTH - 1);
  localparam logic [PH_W-1:0] LD_LOW   = PH_W'(STEP_PERIOD - PULSE_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PH_W-1:0]  r_phase;
  logic [PH_W-1:0]  w_phase_nxt;
  logic [CNT_W-1:0] r_rem1;
  logic [CNT_W-1:0] r_rem2;
  logic [CNT_W-1:0] w_rem1_nxt;
  logic [CNT_W-1:0] w_rem2_nxt;
  logic             r_dir1;
  logic             r_dir2;
  logic             w_dir1_nxt;
  logic             w_dir2_nxt;
  logic             r_step1;
  logic             r_step2;
  logic             w_step1_nxt;
  logic             w_step2_nxt;
  logic             r_aborted;
  logic             w_aborted_nxt;

  logic             w_ready;
  logic             w_accept;
  logic             w_phase_end;

  // Ready is masked while reset is held so every output reads 0 in reset.
  assign w_ready     = (r_state == S_IDLE) && !reset;
  assign w_accept    = io_cmd.cmd_valid && w_ready;
  assign w_phase_end = (r_phase == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = w_phase_end ? '0 : r_phase - 1'b1;
    w_rem1_nxt    = r_rem1;
    w_rem2_nxt    = r_rem2;
    w_dir1_nxt    = r_dir1;
    w_dir2_nxt    = r_dir2;
    w_step1_nxt   = r_step1;
    w_step2_nxt   = r_step2;
    w_aborted_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        if (w_accept) begin
          w_rem1_nxt = io_cmd.cmd_steps1;
          w_rem2_nxt = io_cmd.cmd_steps2;
          w_dir1_nxt = io_cmd.cmd_dir1;
          w_dir2_nxt = io_cmd.cmd_dir2;
          if ((io_cmd.cmd_steps1 == '0) && (io_cmd.cmd_steps2 == '0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SETUP;
            w_phase_nxt = LD_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (w_phase_end) begin
          w_state_nxt = S_HIGH;
          w_phase_nxt = LD_HIGH;
          w_step1_nxt = (r_rem1 != '0);
          w_step2_nxt = (r_rem2 != '0);
        end
      end
      S_HIGH: begin
        if (w_phase_end) begin
          w_state_nxt = S_LOW;
          w_phase_nxt = LD_LOW;
          w_step1_nxt = 1'b0;
          w_step2_nxt = 1'b0;
          if (r_rem1 != '0) w_rem1_nxt = r_rem1 - 1'b1;
          if (r_rem2 != '0) w_rem2_nxt = r_rem2 - 1'b1;
        end
      end
      S_LOW: begin
        if (w_phase_end) begin
          if ((r_rem1 == '0) && (r_rem2 == '0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_HIGH;
            w_phase_nxt = LD_HIGH;
            w_step1_nxt = (r_rem1 != '0);
            w_step2_nxt = (r_rem2 != '0);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state decided this cycle, including a
    // pending decrement at the end of HIGH: counts freeze where they are.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_phase_nxt   = '0;
      w_rem1_nxt    = r_rem1;
      w_rem2_nxt    = r_rem2;
      w_step1_nxt   = 1'b0;
      w_step2_nxt   = 1'b0;
      w_aborted_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_rem1    <= '0;
      r_rem2    <= '0;
      r_dir1    <= 1'b0;
      r_dir2    <= 1'b0;
      r_step1   <= 1'b0;
      r_step2   <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_rem1    <= w_rem1_nxt;
      r_rem2    <= w_rem2_nxt;
      r_dir1    <= w_dir1_nxt;
      r_dir2    <= w_dir2_nxt;
      r_step1   <= w_step1_nxt;
      r_step2   <= w_step2_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign io_cmd.cmd_ready = w_ready;
  assign o_step1          = r_step1;
  assign o_step2          = r_step2;
  assign o_dir1           = r_dir1;
  assign o_dir2           = r_dir2;
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_aborted        = r_aborted;
  assign o_remaining1     = r_rem1;
  assign o_remaining2     = r_rem2;

endmodule
